// File: rtl/bus_decoder.sv
// Single-master address decoder and response mux over NUM_SLAVES windows.
// Unmapped addresses and slaves that never answer complete with ERR_DATA and an err pulse.
module bus_decoder #(
  parameter int          NUM_SLAVES = 4,
  parameter int          IDX_BITS   = 2,
  parameter int          WIN_BITS   = 8,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [3:0]               m_wstrb,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  output logic [3:0]               s_wstrb,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic                     err,
  output logic [7:0]               err_count
);

  localparam int HI = WIN_BITS + IDX_BITS;

  typedef enum logic [1:0] {IDLE, ACCESS, COOL} state_t;

  state_t                state, state_nxt;
  logic [NUM_SLAVES-1:0] dec_oh, sel_oh;
  logic                  hit, sel_ready, timeout_hit, err_flag;
  logic [31:0]           sel_rdata;
  logic [15:0]           count;

  // A window index beyond NUM_SLAVES leaves dec_oh empty and decodes as a miss.
  always_comb begin
    dec_oh = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      dec_oh[i] = (m_addr[WIN_BITS +: IDX_BITS] == IDX_BITS'(i));
    hit = (m_addr[31:HI] == BASE[31:HI]) && (|dec_oh);
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (sel_oh[i]) sel_rdata = sel_rdata | s_rdata[32*i +: 32];
    sel_ready   = |(s_ready & sel_oh);
    timeout_hit = (count == 16'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m_valid) state_nxt = hit ? ACCESS : COOL;
      ACCESS:  if (sel_ready || timeout_hit) state_nxt = COOL;
      COOL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_ready = (state == COOL);
    err     = (state == COOL) && err_flag;
    s_valid = (state == ACCESS) ? sel_oh : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      sel_oh    <= '0;
      count     <= '0;
      m_rdata   <= '0;
      err_flag  <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: if (m_valid) begin
          s_addr   <= m_addr;
          s_wdata  <= m_wdata;
          s_wstrb  <= m_wstrb;
          sel_oh   <= hit ? dec_oh : '0;
          count    <= '0;
          err_flag <= !hit;
          if (!hit) begin
            m_rdata <= ERR_DATA;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        ACCESS: begin
          count <= count + 16'd1;
          // Slave ready wins over a timeout landing in the same cycle.
          if (sel_ready) begin
            m_rdata  <= sel_rdata;
            err_flag <= 1'b0;
          end else if (timeout_hit) begin
            m_rdata  <= ERR_DATA;
            err_flag <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_decoder.sv
// Randomized bench for bus_decoder: reference model expectations queued per request, checked by a monitor.
module tb_bus_decoder;
  localparam int          NS   = 4;
  localparam int          TO   = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset;
  logic          m_valid, m_ready;
  logic [3:0]    m_wstrb, s_wstrb;
  logic [31:0]   m_addr, m_wdata, m_rdata, s_addr, s_wdata;
  logic [NS-1:0] s_valid, s_ready;
  logic [32*NS-1:0] s_rdata;
  logic          err;
  logic [7:0]    err_count;

  bus_decoder #(.NUM_SLAVES(NS), .IDX_BITS(2), .WIN_BITS(8), .BASE(BASE),
                .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_ready(m_ready),
    .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .err(err), .err_count(err_count));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
    logic        err;
    int          idx, sv_cyc, lat;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int txn_exp = 0, txn_seen = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Slave model: ready rises after the slave has seen valid on dly edges (0 = never).
  int dly[NS];
  int vcnt[NS];
  logic [NS-1:0] slv_rdy, noise;
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (reset || !s_valid[i]) begin
        vcnt[i]    <= 0;
        slv_rdy[i] <= 1'b0;
      end else begin
        vcnt[i]    <= vcnt[i] + 1;
        slv_rdy[i] <= (dly[i] != 0) && (vcnt[i] + 1 == dly[i]);
      end
    end
    noise <= NS'($urandom);
  end
  assign s_ready = slv_rdy | (noise & ~s_valid);

  // Posedges with m_valid high since the last completion.
  int lat_cnt;
  always @(posedge clk) begin
    if (reset || !m_valid || m_ready) lat_cnt <= 0;
    else                              lat_cnt <= lat_cnt + 1;
  end

  // Monitor
  int          sv_cyc = 0, model_errs = 0;
  logic [NS-1:0] prev_sv = '0;
  logic [31:0] last_rdata = '0;
  bit          have_last = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sv_cyc = 0; model_errs = 0; have_last = 0; prev_sv = '0;
    end else begin
      if (s_valid != '0) begin
        sv_cyc++;
        if (prev_sv == '0) txn_seen++;
        if (q.size() == 0) check("spurious_svalid", 32'(s_valid), 32'h0);
        else begin
          check("svalid_onehot", 32'(s_valid), 32'(1) << q[0].idx);
          check("s_addr", s_addr, q[0].addr);
          check("s_wdata", s_wdata, q[0].wdata);
          check("s_wstrb", 32'(s_wstrb), 32'(q[0].wstrb));
        end
      end
      prev_sv = s_valid;
      if (m_ready) begin
        if (q.size() == 0) check("spurious_ready", 32'(m_ready), 32'h0);
        else begin
          e = q.pop_front();
          check("m_rdata", m_rdata, e.rdata);
          check("err", 32'(err), 32'(e.err));
          check("latency", 32'(lat_cnt), 32'(e.lat));
          check("svalid_cycles", 32'(sv_cyc), 32'(e.sv_cyc));
          if (e.err && model_errs < 255) model_errs++;
          check("err_count", 32'(err_count), 32'(model_errs));
        end
        last_rdata = m_rdata;
        have_last  = 1;
        sv_cyc     = 0;
      end else begin
        if (err) check("err_without_ready", 32'(err), 32'h0);
        if (have_last) begin
          check("m_rdata_hold", m_rdata, last_rdata);
          have_last = 0;
        end
      end
    end
  end

  // mode: 0 drop after ready, 1 hold m_valid through COOL, 2 back-to-back with next request
  task automatic issue(input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] wd,
                       input logic [31:0] rd, input int d, input int mode);
    exp_t e;
    bit   hit, ok, normal;
    int   idx;
    hit = (addr >= BASE) && (addr < BASE + NS * 256);
    idx = hit ? int'((addr - BASE) >> 8) : -1;
    for (int i = 0; i < NS; i++)
      s_rdata[32*i +: 32] = (i == idx) ? rd : $urandom;
    if (hit) dly[idx] = d;
    normal  = hit && d >= 1 && d < TO;
    e.addr  = addr; e.wdata = wd; e.wstrb = ws; e.idx = idx;
    e.err   = !normal;
    e.rdata = normal ? rd : ERRD;
    e.sv_cyc = !hit ? 0 : (normal ? d + 1 : TO);
    e.lat    = !hit ? 1 : (normal ? d + 2 : TO + 1);
    if (hit) txn_exp++;
    q.push_back(e);
    m_addr = addr; m_wstrb = ws; m_wdata = wd; m_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_ready) begin ok = 1; break; end
    end
    if (!ok) check("ready_timeout", 32'(m_ready), 32'h1);
    if (mode == 1) @(negedge clk);
    if (mode != 2) begin
      m_valid = 1'b0;
      m_addr  = $urandom;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r, md;
    for (int i = 0; i < NS; i++) dly[i] = 1;
    reset = 1'b1; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0; s_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_svalid", 32'(s_valid), 32'h0);
    check("rst_mready", 32'(m_ready), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_errcnt", 32'(err_count), 32'h0);
    check("rst_mrdata", m_rdata, 32'h0);
    check("rst_saddr", s_addr, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    issue(32'h8000_0000, 4'h1, 32'h1, $urandom, 1, 0);
    issue(32'h8000_0204, 4'h0, $urandom, 32'h1234_5678, 1, 0);
    issue(32'h4000_0000, 4'h0, $urandom, $urandom, 1, 0);
    issue(32'h8000_0400, 4'hF, $urandom, $urandom, 1, 0);
    issue(32'h8000_0100, 4'h0, $urandom, $urandom, 0, 0);
    issue(32'h8000_0104, 4'h0, $urandom, 32'hCAFE_0007, 7, 0);
    issue(32'h8000_0108, 4'h3, $urandom, $urandom, 8, 0);

    // Reset in the middle of an access to a hung slave.
    begin
      exp_t e;
      e.addr = 32'h8000_0110; e.wdata = 32'h55; e.wstrb = 4'h2; e.idx = 1;
      e.err = 1; e.rdata = ERRD; e.sv_cyc = TO; e.lat = TO + 1;
      dly[1] = 0; txn_exp++;
      q.push_back(e);
      m_addr = e.addr; m_wdata = e.wdata; m_wstrb = e.wstrb; m_valid = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1; m_valid = 1'b0;
      @(negedge clk);
      q.delete();
      check("midrst_svalid", 32'(s_valid), 32'h0);
      check("midrst_mready", 32'(m_ready), 32'h0);
      check("midrst_errcnt", 32'(err_count), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
    end

    issue(32'h8000_0300, 4'h0, $urandom, $urandom, 1, 1);
    issue(32'h8000_0304, 4'hF, $urandom, $urandom, 3, 2);
    issue(32'h9000_0000, 4'h0, $urandom, $urandom, 1, 2);
    issue(32'h8000_0008, 4'h1, $urandom, $urandom, 2, 0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      a = BASE + 32'($urandom_range(0, NS - 1)) * 256 + 32'($urandom_range(0, 63)) * 4;
      else if (r == 7) a = BASE + NS * 256 + 32'($urandom_range(0, 255)) * 4;
      else if (r == 8) a = $urandom;
      else             a = BASE - 4;
      md = (n == 59) ? 0 : $urandom_range(0, 2);
      issue(a, 4'($urandom), $urandom, $urandom, $urandom_range(0, 9), md);
    end

    for (int n = 0; n < 260; n++)
      issue(32'h0000_1000 + 32'(n) * 4, 4'h0, $urandom, $urandom, 1, (n == 259) ? 0 : $urandom_range(0, 2));

    repeat (3) @(negedge clk);
    check("err_count_saturated", 32'(err_count), 32'd255);
    check("txn_count", 32'(txn_seen), 32'(txn_exp));
    check("queue_empty", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_decoder.md
Name: bus_decoder

Overview:
- Single-master to NUM_SLAVES-slave address decoder and response mux for the peripheral bus (valid/ready/wstrb/addr/wdata/rdata).
- Sits directly upstream of register peripherals such as the single-bit output register.
- Latches each master request and forwards it to exactly one slave window.
- Returns that slave's rdata and a one-cycle ready pulse to the master.
- Terminates unmapped or hung accesses with an error response so the master never stalls.

Parameters:
- NUM_SLAVES, 4, number of slave windows; 1..16.
- IDX_BITS, 2, slave index width; 2^IDX_BITS >= NUM_SLAVES.
- WIN_BITS, 8, log2 of window size in bytes; slave i spans BASE + i*2^WIN_BITS.
- BASE, 32'h8000_0000, region base; bits [WIN_BITS+IDX_BITS-1:0] must be zero.
- TIMEOUT, 255, cycles in ACCESS without slave ready before abort; 1..65535.
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on error.

Ports:
- clk, input, 1, clock; all logic on posedge.
- reset, input, 1, synchronous active-high reset.
- m_valid, input, 1, master request; held until m_ready.
- m_ready, output, 1, one-cycle completion pulse to master.
- m_wstrb, input, 4, byte write strobes; 0 = read.
- m_addr, input, 32, byte address.
- m_wdata, input, 32, write data.
- m_rdata, output, 32, read data; valid when m_ready=1.
- s_valid, output, NUM_SLAVES, one-hot request to the selected slave.
- s_ready, input, NUM_SLAVES, per-slave ready.
- s_wstrb, output, 4, latched strobes, shared by all slaves.
- s_addr, output, 32, latched full address, shared.
- s_wdata, output, 32, latched write data, shared.
- s_rdata, input, 32*NUM_SLAVES, slave i read data at [32*i +: 32].
- err, output, 1, one-cycle pulse on each unmapped or timeout completion.
- err_count, output, 8, saturating count of error completions.

Behaviour:
- Reset values, applied on any posedge with reset=1 regardless of state:
  - state=IDLE; s_valid=0; m_ready=0; err=0; err_count=0.
  - m_rdata=0; s_addr/s_wdata/s_wstrb=0; timeout counter=0.
- Reset mid-transaction drops s_valid on the next cycle and produces no m_ready.
- States: IDLE, ACCESS, COOL.
- IDLE:
  - m_valid=1 latches m_addr/m_wdata/m_wstrb into s_* registers.
  - Decode is a hit when m_addr[31:WIN_BITS+IDX_BITS] == BASE[31:WIN_BITS+IDX_BITS] and idx = m_addr[WIN_BITS +: IDX_BITS] < NUM_SLAVES.
  - Hit: next cycle s_valid[idx]=1, counter=0, go to ACCESS.
  - Miss: next cycle m_ready=1, m_rdata=ERR_DATA, err=1, err_count++, go to COOL; no s_valid is asserted.
- ACCESS:
  - s_valid[idx] is held high, counter increments each cycle.
  - If s_ready[idx]=1:
    - next cycle s_valid=0, m_ready=1, m_rdata=s_rdata[idx] for both reads and writes, go to COOL.
  - Else if counter == TIMEOUT-1:
    - next cycle s_valid=0, m_ready=1, m_rdata=ERR_DATA, err=1, err_count++, go to COOL.
  - s_ready has priority over timeout in the same cycle.
  - s_ready of unselected slaves is ignored.
- COOL:
  - m_ready=1 for exactly this one cycle; m_valid is ignored.
  - Unconditionally return to IDLE next cycle.
  - This absorbs the master's valid deassertion latency, so one request never produces two transactions.
- Latency:
  - Hit with a slave whose ready is registered from valid: m_ready rises 3 cycles after m_valid is first sampled.
  - Miss: m_ready rises 1 cycle after m_valid is first sampled.
- m_rdata holds its value after the m_ready pulse until the next completion.
- err_count saturates at 255.
- s_* payload registers change only on IDLE acceptance.
- s_valid is never asserted on more than one bit.

Test Plan:
- Write to slave 0: m_addr=0x8000_0000, wstrb=0x1, wdata=1, slave ready registered from valid -> s_valid=4'b0001 for 2 cycles, one m_ready pulse, s_wdata=1, err=0.
- Read from slave 2: m_addr=0x8000_0204, s_rdata[2]=0x1234_5678 -> s_addr=0x8000_0204, m_rdata=0x1234_5678 on the m_ready cycle, s_valid[2] only.
- Unmapped address: m_addr=0x4000_0000, then m_addr=0x8000_0400 with NUM_SLAVES=4 -> m_ready 1 cycle after accept, m_rdata=0xDEAD_BEEF, err pulse each time, err_count=2, s_valid stays 0.
- Hung slave: s_ready[1] tied 0, TIMEOUT=8 -> s_valid[1] high exactly 8 cycles, then m_ready with 0xDEAD_BEEF, err=1.
- Ready on the final timeout cycle: s_ready[1] asserted on cycle 8 -> normal completion with slave data, err=0, err_count unchanged.
- Reset during ACCESS, plus back-to-back requests:
  - reset asserted mid-ACCESS -> s_valid=0 next cycle, no m_ready, err_count=0.
  - master holds m_valid through COOL -> exactly one slave transaction per master request.
  - reissued request after COOL -> accepted normally.
